// File: rtl/leaf_link_adapter.sv
// Leaf-side link stage: packs local boundary channels and stage-controller traffic into
// hub messages, and routes hub messages back to the local channels or stage controller.
module leaf_link_adapter #(
  parameter int FPGAID_WIDTH        = 4,
  parameter int FIFO_IDWIDTH        = 3,
  parameter int PAYLOAD_WIDTH       = 16,
  parameter int LOCAL_CHANNEL_COUNT = 4,
  parameter int MY_FPGA_ID          = 1,
  parameter logic [LOCAL_CHANNEL_COUNT*FPGAID_WIDTH-1:0] CHANNEL_DEST_IDS = '0,
  localparam int HUB_FIFO_WIDTH     = FPGAID_WIDTH + FIFO_IDWIDTH + PAYLOAD_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [LOCAL_CHANNEL_COUNT*PAYLOAD_WIDTH-1:0] local_in_data,
  input  logic [LOCAL_CHANNEL_COUNT-1:0]               local_in_valid,
  output logic [LOCAL_CHANNEL_COUNT-1:0]               local_in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]                     ctrl_in_data,
  input  logic                                         ctrl_in_valid,
  output logic                                         ctrl_in_ready,
  output logic [HUB_FIFO_WIDTH-1:0]                    upstream_fifo_out_data,
  output logic                                         upstream_fifo_out_valid,
  input  logic                                         upstream_fifo_out_ready,
  input  logic [HUB_FIFO_WIDTH-1:0]                    upstream_fifo_in_data,
  input  logic                                         upstream_fifo_in_valid,
  output logic                                         upstream_fifo_in_ready,
  output logic [PAYLOAD_WIDTH-1:0]                     local_out_data,
  output logic [LOCAL_CHANNEL_COUNT-1:0]               local_out_valid,
  input  logic [LOCAL_CHANNEL_COUNT-1:0]               local_out_ready,
  output logic [PAYLOAD_WIDTH-1:0]                     ctrl_out_data,
  output logic                                         ctrl_out_valid,
  input  logic                                         ctrl_out_ready,
  input  logic                                         local_has_message_flying,
  input  logic                                         local_has_odd_clusters,
  output logic                                         upstream_has_message_flying,
  output logic                                         upstream_has_odd_clusters,
  output logic [7:0]                                   misroute_count
);

  localparam int CH_W = (LOCAL_CHANNEL_COUNT > 1) ? $clog2(LOCAL_CHANNEL_COUNT) : 1;
  localparam int CW1  = CH_W + 1;
  localparam int FW1  = FIFO_IDWIDTH + 1;

  // ---------------- egress ----------------
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] rr_next;
  logic [CW1-1:0]  cand;
  logic            grant_found;
  logic            can_load;
  logic            load_ctrl;
  logic            load_local;
  logic [PAYLOAD_WIDTH-1:0] grant_payload;
  logic [FPGAID_WIDTH-1:0]  grant_dest;

  // Round-robin search starting at rr_ptr; the first valid channel found wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < LOCAL_CHANNEL_COUNT; k++) begin
      cand = {1'b0, rr_ptr} + CW1'(k);
      if (cand >= CW1'(LOCAL_CHANNEL_COUNT)) begin
        cand = cand - CW1'(LOCAL_CHANNEL_COUNT);
      end
      if (!grant_found && local_in_valid[cand[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[CH_W-1:0];
      end
    end
  end

  assign can_load   = !upstream_fifo_out_valid || upstream_fifo_out_ready;
  assign load_ctrl  = !reset && can_load && ctrl_in_valid;
  assign load_local = !reset && can_load && !ctrl_in_valid && grant_found;
  assign ctrl_in_ready = load_ctrl;

  assign rr_next = (grant_idx == CH_W'(LOCAL_CHANNEL_COUNT - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_payload = local_in_data[int'(grant_idx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
  assign grant_dest    = CHANNEL_DEST_IDS[int'(grant_idx)*FPGAID_WIDTH +: FPGAID_WIDTH];

  always_comb begin
    local_in_ready = '0;
    for (int i = 0; i < LOCAL_CHANNEL_COUNT; i++) begin
      local_in_ready[i] = load_local && (grant_idx == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upstream_fifo_out_valid <= 1'b0;
      upstream_fifo_out_data  <= '0;
      rr_ptr                  <= '0;
    end else if (load_ctrl) begin
      upstream_fifo_out_valid <= 1'b1;
      upstream_fifo_out_data  <= {{FPGAID_WIDTH{1'b0}}, {FIFO_IDWIDTH{1'b1}}, ctrl_in_data};
    end else if (load_local) begin
      upstream_fifo_out_valid <= 1'b1;
      upstream_fifo_out_data  <= {grant_dest, FIFO_IDWIDTH'(grant_idx), grant_payload};
      rr_ptr                  <= rr_next;
    end else if (can_load) begin
      upstream_fifo_out_valid <= 1'b0;
    end
  end

  // ---------------- ingress ----------------
  logic [FPGAID_WIDTH-1:0]        in_dest;
  logic [FIFO_IDWIDTH-1:0]        in_fid;
  logic [PAYLOAD_WIDTH-1:0]       in_payload;
  logic                           in_is_mine;
  logic                           in_is_ctrl;
  logic                           in_is_local;
  logic [LOCAL_CHANNEL_COUNT-1:0] in_onehot;
  logic [LOCAL_CHANNEL_COUNT-1:0] hold_local;
  logic                           hold_ctrl;
  logic [PAYLOAD_WIDTH-1:0]       hold_data;
  logic                           hold_valid;
  logic                           hold_drained;
  logic                           in_accept;

  assign {in_dest, in_fid, in_payload} = upstream_fifo_in_data;
  assign in_is_mine  = (in_dest == FPGAID_WIDTH'(MY_FPGA_ID));
  assign in_is_ctrl  = (in_fid == {FIFO_IDWIDTH{1'b1}});
  assign in_is_local = ({1'b0, in_fid} < FW1'(LOCAL_CHANNEL_COUNT));

  always_comb begin
    in_onehot = '0;
    for (int i = 0; i < LOCAL_CHANNEL_COUNT; i++) begin
      in_onehot[i] = (in_fid == FIFO_IDWIDTH'(i));
    end
  end

  assign hold_valid   = hold_ctrl || (|hold_local);
  assign hold_drained = (hold_ctrl && ctrl_out_ready) || (|(hold_local & local_out_ready));
  assign upstream_fifo_in_ready = !reset && (!hold_valid || hold_drained);
  assign in_accept    = upstream_fifo_in_valid && upstream_fifo_in_ready;

  // Dropped messages are consumed on acceptance and never occupy the hold register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_local     <= '0;
      hold_ctrl      <= 1'b0;
      hold_data      <= '0;
      misroute_count <= '0;
    end else if (in_accept) begin
      if (in_is_mine && in_is_ctrl) begin
        hold_ctrl  <= 1'b1;
        hold_local <= '0;
        hold_data  <= in_payload;
      end else if (in_is_mine && in_is_local) begin
        hold_ctrl  <= 1'b0;
        hold_local <= in_onehot;
        hold_data  <= in_payload;
      end else begin
        hold_ctrl  <= 1'b0;
        hold_local <= '0;
        if (misroute_count != 8'hFF) begin
          misroute_count <= misroute_count + 8'd1;
        end
      end
    end else if (hold_drained) begin
      hold_ctrl  <= 1'b0;
      hold_local <= '0;
    end
  end

  assign local_out_valid = hold_local;
  assign ctrl_out_valid  = hold_ctrl;
  assign local_out_data  = hold_data;
  assign ctrl_out_data   = hold_data;

  // ---------------- status ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      upstream_has_message_flying <= 1'b0;
      upstream_has_odd_clusters   <= 1'b0;
    end else begin
      upstream_has_message_flying <= upstream_fifo_out_valid | hold_valid | (|local_in_valid) |
                                     ctrl_in_valid | upstream_fifo_in_valid |
                                     local_has_message_flying;
      upstream_has_odd_clusters   <= local_has_odd_clusters;
    end
  end

endmodule

// File: tb/tb_leaf_link_adapter.sv
// Testbench for leaf_link_adapter: directed steps plus random traffic checked against a
// queue-based reference model of the egress/ingress paths.
module tb_leaf_link_adapter;

  localparam int FW = 4;
  localparam int IW = 3;
  localparam int PW = 16;
  localparam int N  = 4;
  localparam int HW = FW + IW + PW;

  logic            clk;
  logic            reset;
  logic [N*PW-1:0] local_in_data;
  logic [N-1:0]    local_in_valid;
  logic [N-1:0]    local_in_ready;
  logic [PW-1:0]   ctrl_in_data;
  logic            ctrl_in_valid;
  logic            ctrl_in_ready;
  logic [HW-1:0]   upstream_fifo_out_data;
  logic            upstream_fifo_out_valid;
  logic            upstream_fifo_out_ready;
  logic [HW-1:0]   upstream_fifo_in_data;
  logic            upstream_fifo_in_valid;
  logic            upstream_fifo_in_ready;
  logic [PW-1:0]   local_out_data;
  logic [N-1:0]    local_out_valid;
  logic [N-1:0]    local_out_ready;
  logic [PW-1:0]   ctrl_out_data;
  logic            ctrl_out_valid;
  logic            ctrl_out_ready;
  logic            local_has_message_flying;
  logic            local_has_odd_clusters;
  logic            upstream_has_message_flying;
  logic            upstream_has_odd_clusters;
  logic [7:0]      misroute_count;

  leaf_link_adapter #(
    .FPGAID_WIDTH(FW), .FIFO_IDWIDTH(IW), .PAYLOAD_WIDTH(PW), .LOCAL_CHANNEL_COUNT(N),
    .MY_FPGA_ID(1), .CHANNEL_DEST_IDS({4'd7, 4'd5, 4'd2, 4'd3})
  ) dut (
    .clk(clk), .reset(reset),
    .local_in_data(local_in_data), .local_in_valid(local_in_valid),
    .local_in_ready(local_in_ready),
    .ctrl_in_data(ctrl_in_data), .ctrl_in_valid(ctrl_in_valid), .ctrl_in_ready(ctrl_in_ready),
    .upstream_fifo_out_data(upstream_fifo_out_data),
    .upstream_fifo_out_valid(upstream_fifo_out_valid),
    .upstream_fifo_out_ready(upstream_fifo_out_ready),
    .upstream_fifo_in_data(upstream_fifo_in_data),
    .upstream_fifo_in_valid(upstream_fifo_in_valid),
    .upstream_fifo_in_ready(upstream_fifo_in_ready),
    .local_out_data(local_out_data), .local_out_valid(local_out_valid),
    .local_out_ready(local_out_ready),
    .ctrl_out_data(ctrl_out_data), .ctrl_out_valid(ctrl_out_valid),
    .ctrl_out_ready(ctrl_out_ready),
    .local_has_message_flying(local_has_message_flying),
    .local_has_odd_clusters(local_has_odd_clusters),
    .upstream_has_message_flying(upstream_has_message_flying),
    .upstream_has_odd_clusters(upstream_has_odd_clusters),
    .misroute_count(misroute_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: queue of packed messages waiting for the hub, queue of routed
  // ingress messages (target -1 = stage controller), round-robin turn, drop counter.
  typedef struct {
    int            target;
    logic [PW-1:0] payload;
  } ig_entry_t;

  logic [HW-1:0] eg_q[$];
  ig_entry_t     ig_q[$];
  int            rr_exp   = 0;
  int            mis_exp  = 0;
  logic          fly_exp  = 1'b0;
  logic          odd_exp  = 1'b0;
  int            dest_tbl[N] = '{3, 2, 5, 7};
  int            rr_ref[5]   = '{0, 1, 2, 3, 0};
  logic          recording = 1'b0;
  int            seen_ids[$];

  function automatic logic [HW-1:0] make_msg(input int dest, input int fid,
                                             input logic [PW-1:0] p);
    return {FW'(dest), IW'(fid), p};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model over the edge.
  task automatic tick();
    logic          can_load;
    logic          exp_cr;
    logic [N-1:0]  exp_lr;
    logic [N-1:0]  exp_lov;
    logic          exp_cov;
    logic          drained;
    logic          exp_ir;
    logic          fly_next;
    logic          odd_next;
    logic          c_reset;
    logic          c_out_ready;
    logic          c_in_valid;
    logic [HW-1:0] c_in_data;
    logic [PW-1:0] c_ctrl_data;
    logic [N*PW-1:0] c_local_data;
    int            g;
    int            dest;
    int            fid;
    ig_entry_t     e;

    #1;
    can_load = (eg_q.size() == 0) || upstream_fifo_out_ready;
    exp_cr = 1'b0;
    exp_lr = '0;
    g = -1;
    if (!reset && can_load) begin
      if (ctrl_in_valid) exp_cr = 1'b1;
      else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && local_in_valid[(rr_exp + k) % N]) g = (rr_exp + k) % N;
        end
        if (g >= 0) exp_lr[g] = 1'b1;
      end
    end
    exp_lov = '0;
    exp_cov = 1'b0;
    if (ig_q.size() != 0) begin
      if (ig_q[0].target < 0) exp_cov = 1'b1;
      else exp_lov[ig_q[0].target] = 1'b1;
    end
    drained = (exp_cov && ctrl_out_ready) || ((exp_lov & local_out_ready) != '0);
    exp_ir = !reset && ((ig_q.size() == 0) || drained);

    check_output("out_valid", upstream_fifo_out_valid, eg_q.size() != 0);
    if (eg_q.size() != 0) check_output("out_data", upstream_fifo_out_data, eg_q[0]);
    check_output("ctrl_in_ready", ctrl_in_ready, exp_cr);
    check_output("local_in_ready", local_in_ready, exp_lr);
    check_output("in_ready", upstream_fifo_in_ready, exp_ir);
    check_output("local_out_valid", local_out_valid, exp_lov);
    check_output("ctrl_out_valid", ctrl_out_valid, exp_cov);
    if (exp_cov) check_output("ctrl_out_data", ctrl_out_data, ig_q[0].payload);
    if (exp_lov != '0) check_output("local_out_data", local_out_data, ig_q[0].payload);
    check_output("misroute_count", misroute_count, mis_exp);
    check_output("flying", upstream_has_message_flying, fly_exp);
    check_output("odd", upstream_has_odd_clusters, odd_exp);

    if (recording && upstream_fifo_out_valid && upstream_fifo_out_ready)
      seen_ids.push_back(int'(upstream_fifo_out_data[PW +: IW]));

    fly_next = (eg_q.size() != 0) || (ig_q.size() != 0) || (local_in_valid != '0) ||
               ctrl_in_valid || upstream_fifo_in_valid || local_has_message_flying;
    odd_next     = local_has_odd_clusters;
    c_reset      = reset;
    c_out_ready  = upstream_fifo_out_ready;
    c_in_valid   = upstream_fifo_in_valid;
    c_in_data    = upstream_fifo_in_data;
    c_ctrl_data  = ctrl_in_data;
    c_local_data = local_in_data;

    @(posedge clk);
    if (c_reset) begin
      eg_q.delete();
      ig_q.delete();
      rr_exp  = 0;
      mis_exp = 0;
      fly_exp = 1'b0;
      odd_exp = 1'b0;
    end else begin
      fly_exp = fly_next;
      odd_exp = odd_next;
      if (eg_q.size() != 0 && c_out_ready) void'(eg_q.pop_front());
      if (exp_cr) eg_q.push_back(make_msg(0, 7, c_ctrl_data));
      else if (g >= 0) begin
        eg_q.push_back(make_msg(dest_tbl[g], g, c_local_data[g*PW +: PW]));
        rr_exp = (g + 1) % N;
      end
      if (drained) void'(ig_q.pop_front());
      if (c_in_valid && exp_ir) begin
        dest = int'(c_in_data[HW-1 -: FW]);
        fid  = int'(c_in_data[PW +: IW]);
        if (dest != 1 || (fid != 7 && fid >= N)) begin
          if (mis_exp < 255) mis_exp++;
        end else begin
          e.target  = (fid == 7) ? -1 : fid;
          e.payload = c_in_data[PW-1:0];
          ig_q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [N-1:0] lv, input logic cv, input logic our,
                                input logic iv, input logic [HW-1:0] idata,
                                input logic [N-1:0] lor, input logic cor);
    local_in_valid          = lv;
    local_in_data           = {$urandom, $urandom};
    ctrl_in_valid           = cv;
    ctrl_in_data            = PW'($urandom);
    upstream_fifo_out_ready = our;
    upstream_fifo_in_valid  = iv;
    upstream_fifo_in_data   = idata;
    local_out_ready         = lor;
    ctrl_out_ready          = cor;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    local_in_data = '0; local_in_valid = '0; ctrl_in_data = '0; ctrl_in_valid = 1'b0;
    upstream_fifo_out_ready = 1'b0; upstream_fifo_in_data = '0; upstream_fifo_in_valid = 1'b0;
    local_out_ready = '0; ctrl_out_ready = 1'b0;
    local_has_message_flying = 1'b0; local_has_odd_clusters = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Round-robin over four always-valid channels.
    recording = 1'b1;
    repeat (6) apply_stimulus(4'hF, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    recording = 1'b0;
    for (int i = 0; i < 5; i++)
      check_output($sformatf("rr_order%0d", i), (seen_ids.size() > i) ? seen_ids[i] : -1,
                   rr_ref[i]);

    // Controller priority while the hub stalls.
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    apply_stimulus(4'b0010, 1'b1, 1'b0, 1'b0, '0, 4'hF, 1'b1);
    repeat (3) apply_stimulus(4'b0010, 1'b0, 1'b0, 1'b0, '0, 4'hF, 1'b1);
    check_output("ctrl_header", upstream_fifo_out_data[HW-1:PW], 7'h07);
    apply_stimulus(4'b0010, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);

    // Ingress routing to a channel then to the controller.
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1, make_msg(1, 2, 16'hABCD), 4'hF, 1'b1);
    check_output("route_ch2_valid", local_out_valid, 4'b0100);
    check_output("route_ch2_data", local_out_data, 16'hABCD);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1, make_msg(1, 7, 16'h1234), 4'hF, 1'b1);
    check_output("route_ctrl_valid", ctrl_out_valid, 1'b1);
    check_output("route_ctrl_data", ctrl_out_data, 16'h1234);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);

    // Ingress stall on channel 0.
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1, make_msg(1, 0, 16'h1111), 4'b1110, 1'b1);
    repeat (5) apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1, make_msg(1, 0, 16'h2222), 4'b1110, 1'b1);
    check_output("stall_in_ready", upstream_fifo_in_ready, 1'b0);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1, make_msg(1, 0, 16'h2222), 4'hF, 1'b1);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);

    // Odd-cluster pulse follows one cycle later.
    local_has_odd_clusters = 1'b1;
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    local_has_odd_clusters = 1'b0;
    check_output("odd_pulse_hi", upstream_has_odd_clusters, 1'b1);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    check_output("odd_pulse_lo", upstream_has_odd_clusters, 1'b0);

    // Random traffic on both paths.
    for (int i = 0; i < 250; i++) begin
      local_has_message_flying = 1'($urandom);
      local_has_odd_clusters   = 1'($urandom);
      apply_stimulus(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                     1'($urandom),
                     make_msg(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 1,
                              int'($urandom_range(0, 7)), PW'($urandom)),
                     N'($urandom), 1'($urandom));
    end
    local_has_message_flying = 1'b0;
    local_has_odd_clusters   = 1'b0;

    // Reset in the middle of egress, then round-robin restarts at channel 0.
    apply_stimulus(4'hF, 1'b0, 1'b0, 1'b0, '0, 4'hF, 1'b1);
    reset = 1'b1;
    apply_stimulus(4'hF, 1'b0, 1'b0, 1'b0, '0, 4'hF, 1'b1);
    reset = 1'b0;
    check_output("reset_out_valid", upstream_fifo_out_valid, 1'b0);
    check_output("reset_misroute", misroute_count, 8'd0);
    apply_stimulus(4'hF, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    check_output("reset_rr_valid", upstream_fifo_out_valid, 1'b1);
    check_output("reset_rr_ch0", upstream_fifo_out_data[PW +: IW], 3'd0);

    // Misroutes: wrong destination, out-of-range fifo id, then a saturating flood.
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1, make_msg(4, 0, PW'($urandom)), 4'hF, 1'b1);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1, make_msg(1, 5, PW'($urandom)), 4'hF, 1'b1);
    check_output("misroute_two", misroute_count, 8'd2);
    check_output("misroute_no_local", local_out_valid, 4'h0);
    check_output("misroute_no_ctrl", ctrl_out_valid, 1'b0);
    for (int i = 0; i < 300; i++)
      apply_stimulus(4'h0, 1'b0, 1'b1, 1'b1,
                     make_msg(int'($urandom_range(2, 15)), int'($urandom_range(0, 7)),
                              PW'($urandom)), 4'hF, 1'b1);
    apply_stimulus(4'h0, 1'b0, 1'b1, 1'b0, '0, 4'hF, 1'b1);
    check_output("misroute_saturate", misroute_count, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
